// File: rtl/div_seq_ctrl.sv
// div_seq_ctrl: multi-cycle restoring divider sequencer for DIV/DIVU.
// Latches operands on a start handshake, then runs one restoring step per clock
// for WIDTH steps. It applies sign correction and presents {remainder, quotient}
// on Z with a one-cycle done pulse.
module div_seq_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic               clock,
  input  logic               clear,
  input  logic               start,
  input  logic               signed_op,
  input  logic [WIDTH-1:0]   RegA,
  input  logic [WIDTH-1:0]   RegB,
  output logic               busy,
  output logic               done,
  output logic               div_zero,
  output logic [2*WIDTH-1:0] Z
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_ITER = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t              state_q;
  logic [WIDTH-1:0]    opa_q;       // latched dividend (raw)
  logic [WIDTH-1:0]    opb_q;       // latched divisor (raw)
  logic                sgn_q;       // latched signed_op
  logic [WIDTH-1:0]    a_q;         // partial remainder; always < M, so WIDTH bits suffice
  logic [WIDTH-1:0]    q_q;         // dividend magnitude shifting out / quotient shifting in
  logic [WIDTH-1:0]    m_q;         // divisor magnitude
  logic [CW-1:0]       cnt_q;       // step counter
  logic                neg_q_q;     // quotient needs negation
  logic                neg_r_q;     // remainder needs negation
  logic                busy_q;
  logic                done_q;
  logic                div_zero_q;
  logic [2*WIDTH-1:0]  z_q;

  // Operand magnitudes for PREP: negate only when signed and MSB set.
  // The negation of the most negative value wraps to itself, which read as an
  // unsigned number is exactly its magnitude.
  logic                a_neg;
  logic                b_neg;
  logic [WIDTH-1:0]    mag_a;
  logic [WIDTH-1:0]    mag_b;

  assign a_neg = sgn_q & opa_q[WIDTH-1];
  assign b_neg = sgn_q & opb_q[WIDTH-1];
  assign mag_a = a_neg ? (-opa_q) : opa_q;
  assign mag_b = b_neg ? (-opb_q) : opb_q;

  // One restoring step: shift {A,Q} left, trial-subtract M in WIDTH+1 bits,
  // keep the difference when its sign bit is clear.
  logic [WIDTH:0]      a_shift;
  logic [WIDTH:0]      trial;
  logic [WIDTH-1:0]    a_step;
  logic [WIDTH-1:0]    q_step;
  logic                last_step;

  always_comb begin
    a_shift   = {a_q, q_q[WIDTH-1]};
    trial     = a_shift - {1'b0, m_q};
    a_step    = trial[WIDTH] ? a_shift[WIDTH-1:0] : trial[WIDTH-1:0];
    q_step    = {q_q[WIDTH-2:0], ~trial[WIDTH]};
    last_step = (cnt_q == CW'(WIDTH - 1));
  end

  // Sign correction applied in FIX.
  logic [WIDTH-1:0]    quo_fix;
  logic [WIDTH-1:0]    rem_fix;

  assign quo_fix = neg_q_q ? (-q_q) : q_q;
  assign rem_fix = neg_r_q ? (-a_q) : a_q;

  // Sequencer FSM with registered status outputs and result.
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q    <= S_IDLE;
      opa_q      <= '0;
      opb_q      <= '0;
      sgn_q      <= 1'b0;
      a_q        <= '0;
      q_q        <= '0;
      m_q        <= '0;
      cnt_q      <= '0;
      neg_q_q    <= 1'b0;
      neg_r_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      z_q        <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            opa_q   <= RegA;
            opb_q   <= RegB;
            sgn_q   <= signed_op;
            busy_q  <= 1'b1;
            state_q <= S_PREP;
          end
        end
        S_PREP: begin
          neg_q_q <= a_neg ^ b_neg;
          neg_r_q <= a_neg;
          a_q     <= '0;
          q_q     <= mag_a;
          m_q     <= mag_b;
          cnt_q   <= '0;
          if (mag_b == '0) begin
            // Divide by zero: skip the iterations, report all-ones quotient
            // and the untouched dividend as remainder.
            z_q        <= {opa_q, {WIDTH{1'b1}}};
            div_zero_q <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            state_q    <= S_DONE;
          end else begin
            state_q <= S_ITER;
          end
        end
        S_ITER: begin
          a_q <= a_step;
          q_q <= q_step;
          if (last_step) begin
            cnt_q   <= '0;
            state_q <= S_FIX;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_FIX: begin
          z_q        <= {rem_fix, quo_fix};
          div_zero_q <= 1'b0;
          busy_q     <= 1'b0;
          done_q     <= 1'b1;
          state_q    <= S_DONE;
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = div_zero_q;
  assign Z        = z_q;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Testbench for div_seq_ctrl: directed cases plus randomized regression,
// checked through an expected-result queue drained by a done-driven monitor.
module tb_div_seq_ctrl;

  logic        clock;
  logic        clear;
  logic        start;
  logic        signed_op;
  logic [31:0] RegA;
  logic [31:0] RegB;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [63:0] Z;

  div_seq_ctrl #(.WIDTH(32)) dut (
    .clock     (clock),
    .clear     (clear),
    .start     (start),
    .signed_op (signed_op),
    .RegA      (RegA),
    .RegB      (RegB),
    .busy      (busy),
    .done      (done),
    .div_zero  (div_zero),
    .Z         (Z)
  );

  typedef struct {
    logic [63:0] z;
    logic        dz;
    int          t;        // cycle number in which start was sampled
    int          lat;      // cycles from start to done
    int          busy_len; // consecutive busy cycles before done
  } exp_t;

  exp_t sb[$];

  int vectors;
  int miscompares;
  int cyc;
  int done_cnt;
  int busy_run;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #(10 * 95000);
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer division in 64-bit arithmetic.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
    exp_t   e;
    longint na;
    longint nb;
    longint qq;
    longint rr;
    e.t = 0;
    if (b == 32'd0) begin
      e.z        = {a, 32'hFFFF_FFFF};
      e.dz       = 1'b1;
      e.lat      = 2;
      e.busy_len = 1;
    end else begin
      if (s) begin
        na = longint'($signed(a));
        nb = longint'($signed(b));
      end else begin
        na = longint'({32'd0, a});
        nb = longint'({32'd0, b});
      end
      qq = na / nb;
      rr = na % nb;
      e.z        = {rr[31:0], qq[31:0]};
      e.dz       = 1'b0;
      e.lat      = 35;
      e.busy_len = 34;
    end
    return e;
  endfunction

  // Monitor: on each done pulse, pop the oldest expectation and compare.
  initial begin
    exp_t e;
    busy_run = 0;
    done_cnt = 0;
    forever begin
      @(negedge clock);
      if (busy) begin
        busy_run++;
      end else if (done) begin
        done_cnt++;
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_done: got done=1 required done=0 (cycle %0d)", cyc);
        end else begin
          e = sb.pop_front();
          check("Z", Z, e.z);
          check("div_zero", {63'd0, div_zero}, {63'd0, e.dz});
          check("latency", 64'(cyc - e.t), 64'(e.lat));
          check("busy_len", 64'(busy_run), 64'(e.busy_len));
          $display("op t=%0d Z=%h dz=%0d", e.t, Z, div_zero);
        end
        busy_run = 0;
      end else begin
        busy_run = 0;
      end
    end
  end

  // Present an accepted start in the current IDLE cycle and record its expectation.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s);
    exp_t e;
    @(negedge clock);
    e       = model(a, b, s);
    e.t     = cyc;
    RegA    = a;
    RegB    = b;
    signed_op = s;
    start   = 1'b1;
    sb.push_back(e);
    @(posedge clock);
    #1;
    start = 1'b0;
    RegA  = $urandom;
    RegB  = $urandom;
    signed_op = 1'($urandom_range(0, 1));
  endtask

  // Pulse start without expecting a response (DUT should ignore it).
  task automatic pulse_ignored(input logic [31:0] a, input logic [31:0] b, input logic s);
    RegA      = a;
    RegB      = b;
    signed_op = s;
    start     = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  task automatic goto_cycle(input int target);
    forever begin
      @(negedge clock);
      if (cyc >= target) break;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (sb.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL done_timeout: got no done required done within 100 cycles");
      sb.delete();
    end
  endtask

  initial begin
    int          t0;
    int          d0;
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    vectors     = 0;
    miscompares = 0;
    cyc         = 0;
    clear       = 1'b1;
    start       = 1'b0;
    signed_op   = 1'b0;
    RegA        = '0;
    RegB        = '0;

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    clear = 1'b0;
    @(negedge clock);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_div_zero", {63'd0, div_zero}, 64'd0);
    check("rst_Z", Z, 64'd0);

    // Directed results
    issue(32'd100, 32'd7, 1'b1);          wait_idle();
    issue(-32'sd100, 32'd7, 1'b1);        wait_idle();
    issue(32'd100, -32'sd7, 1'b1);        wait_idle();
    issue(32'hFFFF_FFFF, 32'd2, 1'b0);    wait_idle();
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1); wait_idle();
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b0); wait_idle();
    issue(32'd55, 32'd0, 1'b1);           wait_idle();
    issue(32'hFFFF_FF00, 32'd0, 1'b0);    wait_idle();

    // Reset in the middle of ITER abandons the operation
    issue(32'd100, 32'd7, 1'b1);
    t0 = sb[0].t;
    goto_cycle(t0 + 10);
    clear = 1'b1;
    sb.delete();
    @(posedge clock);
    #1;
    clear = 1'b0;
    @(negedge clock);
    check("midrst_busy", {63'd0, busy}, 64'd0);
    check("midrst_done", {63'd0, done}, 64'd0);
    check("midrst_Z", Z, 64'd0);
    check("midrst_div_zero", {63'd0, div_zero}, 64'd0);
    issue(32'd9, 32'd3, 1'b1);            wait_idle();

    // start while busy and in DONE is ignored; start right after DONE accepted
    d0 = done_cnt;
    issue(32'd100, 32'd7, 1'b1);
    t0 = sb[0].t;
    goto_cycle(t0 + 5);
    pulse_ignored(32'd9, 32'd3, 1'b1);
    goto_cycle(t0 + 35);
    pulse_ignored(32'd9, 32'd3, 1'b1);
    issue(32'd9, 32'd3, 1'b1);
    check("restart_cycle", 64'(sb[sb.size()-1].t - t0), 64'd36);
    wait_idle();
    repeat (40) @(negedge clock);
    check("done_count", 64'(done_cnt - d0), 64'd2);

    // Randomized regression
    for (int i = 0; i < 1000; i++) begin
      a = $urandom;
      s = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0: b = $urandom;
        1: b = 32'($urandom_range(1, 15));
        2: b = -32'($urandom_range(1, 15));
        3: b = 32'hFFFF_FFFF;
        4: b = $urandom >> $urandom_range(0, 31);
        default: b = 32'h8000_0000;
      endcase
      if (b == 32'd0) b = 32'd1;
      if ($urandom_range(0, 15) == 0) a = 32'h8000_0000;
      issue(a, b, s);
      wait_idle();
      repeat ($urandom_range(0, 2)) @(negedge clock);
    end

    repeat (5) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
